// File: rtl/seq_datapath_if.sv
// Control/data bus between the host+controller side and seq_datapath.
//   start     : one-cycle run request
//   data_in   : load data for memory A
//   num       : current step number presented to the controller
//   WEA/WEB   : write enables for memories A and B
//   IncA/IncB : address increment strobes
//   busy/done : run in progress / run-complete pulse
//   rd_addr   : host read address into memory B
//   rd_data   : registered read data from memory B
interface seq_datapath_if #(
  parameter int unsigned DW = 8
);
  logic          start;
  logic [DW-1:0] data_in;
  logic [4:0]    num;
  logic          WEA;
  logic          WEB;
  logic          IncA;
  logic          IncB;
  logic          busy;
  logic          done;
  logic [1:0]    rd_addr;
  logic [DW-1:0] rd_data;

  // Datapath side
  modport slave (
    input  start, data_in, WEA, WEB, IncA, IncB, rd_addr,
    output num, busy, done, rd_data
  );

  // Host/controller side
  modport master (
    output start, data_in, WEA, WEB, IncA, IncB, rd_addr,
    input  num, busy, done, rd_data
  );
endinterface

// File: rtl/seq_datapath.sv
// Step sequencer and memory datapath driven by the controller strobes.
// Generates step number num (0..LAST_STEP during a run, LAST_STEP+1 when
// idle), applies WEA/WEB/IncA/IncB each edge, loads memory A (8 words) from
// data_in and copies words from A into memory B (4 words), which the host
// reads through a registered port.
//   clk   : rising-edge clock
//   Reset : synchronous, active-high; clears state, addresses and memories
//   bus   : seq_datapath_if slave modport (see interface for signal list)
module seq_datapath #(
  parameter int unsigned DW        = 8,
  parameter int unsigned LAST_STEP = 18
) (
  input  logic          clk,
  input  logic          Reset,
  seq_datapath_if.slave bus
);

  localparam int unsigned NUM_W   = 5;
  localparam int unsigned AA_W    = 3;
  localparam int unsigned AB_W    = 2;
  localparam int unsigned A_DEPTH = 8;
  localparam int unsigned B_DEPTH = 4;

  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(LAST_STEP);
  localparam logic [NUM_W-1:0] NUM_IDLE = NUM_W'(LAST_STEP + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [NUM_W-1:0] num_q,     num_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [AA_W-1:0]  addr_a_q,  addr_a_d;
  logic [AB_W-1:0]  addr_b_q,  addr_b_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic [DW-1:0]    mem_a_q [A_DEPTH];
  logic [DW-1:0]    mem_a_d [A_DEPTH];
  logic [DW-1:0]    mem_b_q [B_DEPTH];
  logic [DW-1:0]    mem_b_d [B_DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)         state_d = S_RUN;
      S_RUN:   if (num_q == NUM_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath/output next values. Strobes are applied in every state; with the
  // controller attached they are all zero at the idle step value.
  always_comb begin
    num_d     = num_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_a_d  = addr_a_q + AA_W'(bus.IncA);
    addr_b_d  = addr_b_q + AB_W'(bus.IncB);
    mem_a_d   = mem_a_q;
    mem_b_d   = mem_b_q;
    rd_data_d = mem_b_q[bus.rd_addr];

    // Both writes use pre-increment addresses; WEB copies the pre-edge A word
    if (bus.WEA) mem_a_d[addr_a_q] = bus.data_in;
    if (bus.WEB) mem_b_d[addr_b_q] = mem_a_q[addr_a_q];

    case (state_q)
      S_IDLE: begin
        num_d  = NUM_IDLE;
        busy_d = 1'b0;
        if (bus.start) begin
          num_d    = '0;
          busy_d   = 1'b1;
          addr_a_d = '0;
          addr_b_d = '0;
        end
      end
      S_RUN: begin
        if (num_q == NUM_LAST) begin
          num_d  = NUM_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          num_d = num_q + NUM_W'(1);
        end
      end
      default: begin
        num_d  = NUM_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath registers and memories
  always_ff @(posedge clk) begin
    if (Reset) begin
      num_q     <= NUM_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      rd_data_q <= '0;
      mem_a_q   <= '{default: '0};
      mem_b_q   <= '{default: '0};
    end else begin
      num_q     <= num_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      rd_data_q <= rd_data_d;
      mem_a_q   <= mem_a_d;
      mem_b_q   <= mem_b_d;
    end
  end

  assign bus.num     = num_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Testbench for seq_datapath: table of full runs driven through a model of
// the standard controller table, plus directed reset/abort/wrap sequences.
module tb_seq_datapath;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  seq_datapath_if #(.DW(DW)) bus ();

  seq_datapath #(.DW(DW), .LAST_STEP(18)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic          ctl_en;
  logic [7:0]    words [8];
  logic          man_wea, man_web, man_inca, man_incb;
  logic [7:0]    man_data;

  // Standard controller table (or manual strobes) plus data feed
  always_comb begin
    bus.WEA     = 1'b0;
    bus.WEB     = 1'b0;
    bus.IncA    = 1'b0;
    bus.IncB    = 1'b0;
    bus.data_in = 8'hEE;
    if (ctl_en) begin
      case (bus.num)
        5'd0:                         bus.IncA = 1'b1;
        5'd1, 5'd2, 5'd3, 5'd4,
        5'd5, 5'd6, 5'd7, 5'd8: begin bus.WEA = 1'b1; bus.IncA = 1'b1; end
        5'd9, 5'd10, 5'd12, 5'd14, 5'd16: bus.IncA = 1'b1;
        5'd11, 5'd13, 5'd15: begin bus.WEB = 1'b1; bus.IncB = 1'b1; bus.IncA = 1'b1; end
        5'd17: begin bus.WEB = 1'b1; bus.IncB = 1'b1; end
        default: ;
      endcase
      if (bus.num >= 5'd1 && bus.num <= 5'd8) bus.data_in = words[3'(bus.num - 5'd1)];
    end else begin
      bus.WEA     = man_wea;
      bus.WEB     = man_web;
      bus.IncA    = man_inca;
      bus.IncB    = man_incb;
      bus.data_in = man_data;
    end
  end

  typedef struct packed {
    logic [7:0][7:0] w;    // w[0] is loaded at num=1
    logic [3:0][7:0] eb;   // expected mem_b[0..3]
    logic            b2b;  // start issued in the done cycle of the previous run
    int              poke; // num at which a stray start is pulsed (-1: none)
  } run_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_b(input logic [1:0] a, input logic [7:0] exp, input string name);
    bus.rd_addr = a;
    @(posedge clk); #1;
    check(name, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic man_edge(input logic wea, input logic web, input logic inca,
                          input logic incb, input logic [7:0] d);
    man_wea = wea; man_web = web; man_inca = inca; man_incb = incb; man_data = d;
    @(posedge clk); #1;
    man_wea = 1'b0; man_web = 1'b0; man_inca = 1'b0; man_incb = 1'b0;
  endtask

  task automatic do_run(input run_t r, input string tag);
    int n;
    for (int i = 0; i < 8; i++) words[i] = r.w[i];
    ctl_en    = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      check({tag, "_num"},  32'(bus.num),  32'(n));
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (n == r.poke) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    check({tag, "_done"},      32'(bus.done), 32'd1);
    check({tag, "_len"},       32'(n),        32'd19);
    check({tag, "_num_done"},  32'(bus.num),  32'd19);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic read_all(input logic [3:0][7:0] eb, input string tag);
    for (int a = 0; a < 4; a++) read_b(2'(a), eb[a], $sformatf("%s_memb%0d", tag, a));
  endtask

  run_t runs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones;
    logic [3:0][7:0] zeros;
    zeros = '0;

    runs[0] = '{w: {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11},
                eb: {8'h11, 8'h77, 8'h55, 8'h33}, b2b: 1'b0, poke: -1};
    runs[1] = '{w: {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
                eb: {8'h01, 8'h07, 8'h05, 8'h03}, b2b: 1'b0, poke: -1};
    runs[2] = '{w: {8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1},
                eb: {8'hA1, 8'hA7, 8'hA5, 8'hA3}, b2b: 1'b1, poke: -1};
    runs[3] = '{w: {8'hF8, 8'hF7, 8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1},
                eb: {8'hF1, 8'hF7, 8'hF5, 8'hF3}, b2b: 1'b0, poke: 5};

    // Reset with random strobes and start
    Reset = 1'b1; ctl_en = 1'b0; bus.start = 1'b0; bus.rd_addr = 2'd0;
    man_wea = 1'b0; man_web = 1'b0; man_inca = 1'b0; man_incb = 1'b0; man_data = 8'h00;
    for (int i = 0; i < 8; i++) words[i] = 8'h00;
    for (int c = 0; c < 2; c++) begin
      man_wea  = 1'($urandom); man_web  = 1'($urandom);
      man_inca = 1'($urandom); man_incb = 1'($urandom);
      man_data = 8'($urandom); bus.start = 1'($urandom);
      @(posedge clk); #1;
    end
    man_wea = 1'b0; man_web = 1'b0; man_inca = 1'b0; man_incb = 1'b0; bus.start = 1'b0;
    Reset = 1'b0;
    check("rst_num",  32'(bus.num),     32'd19);
    check("rst_busy", 32'(bus.busy),    32'd0);
    check("rst_done", 32'(bus.done),    32'd0);
    check("rst_rd",   32'(bus.rd_data), 32'd0);
    read_all(zeros, "rst");

    // Table of full runs; a run followed by a back-to-back run is not read back
    for (int i = 0; i < 4; i++) begin
      do_run(runs[i], $sformatf("run%0d", i));
      if (i == 3 || !runs[(i < 3) ? i + 1 : i].b2b) read_all(runs[i].eb, $sformatf("run%0d", i));
    end

    // Abort with Reset at num=12
    for (int i = 0; i < 8; i++) words[i] = runs[0].w[i];
    ctl_en = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 40 && bus.num != 5'd12; c++) begin
      @(posedge clk); #1;
    end
    check("abort_reach12", 32'(bus.num), 32'd12);
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    check("abort_num",  32'(bus.num),  32'd19);
    check("abort_busy", 32'(bus.busy), 32'd0);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    check("abort_nodone", 32'(dones), 32'd0);
    read_all(zeros, "abort");
    do_run(runs[0], "after_abort");
    read_all(runs[0].eb, "after_abort");

    // Directed strobes: address wrap and simultaneous WEA/WEB
    ctl_en = 1'b0;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    man_inca = 1'b1;
    repeat (9) @(posedge clk);
    #1 man_inca = 1'b0;
    check("wrap_addr_a", 32'(dut.addr_a_q), 32'd1);
    man_incb = 1'b1;
    repeat (5) @(posedge clk);
    #1 man_incb = 1'b0;
    check("wrap_addr_b", 32'(dut.addr_b_q), 32'd1);
    man_edge(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);   // mem_a[1] = 3C
    man_edge(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);   // mem_b[1] = 3C
    man_edge(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);   // addr_b = 2
    bus.rd_addr = 2'd2;
    man_edge(1'b1, 1'b1, 1'b0, 1'b0, 8'h96);   // mem_b[2] = old 3C, mem_a[1] = 96
    check("rdw_old", 32'(bus.rd_data), 32'd0);
    man_edge(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);   // addr_b = 3
    man_edge(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);   // mem_b[3] = 96
    read_all({8'h96, 8'h3C, 8'h3C, 8'h00}, "wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
